// File: rtl/fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared constants, helper function and operation encoding for the FIFO
// controller/arbiter slice (fifo_ctrl_arb, rr_arbiter) and its testbench.
//
// Contents:
//   FIFO_DEPTH_DEF / NUM_REQ_DEF : default parameter values
//   clog2_min1()                 : ceil(log2(n)) but never below 1, so that
//                                  index vectors always have at least one bit
//   fifo_op_e                    : per-cycle pointer/count update selector,
//                                  encoded as {pop_accepted, push_accepted}
// -----------------------------------------------------------------------------
package fifo_ctrl_pkg;

  localparam int FIFO_DEPTH_DEF = 16;
  localparam int NUM_REQ_DEF    = 4;

  // Encoding is {pop, push} so the enum can be built directly from the strobes.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered "last granted" pointer. The grant is
// purely combinational: the search starts one past the last granted index,
// wraps modulo NUM_REQ and the first asserted request wins. The pointer only
// moves when a grant is actually issued (en=1 and some req set).
//
// Parameters:
//   NUM_REQ : number of requesters (2..8)
//   IW      : index width, derived from NUM_REQ (do not override)
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset (last grant -> NUM_REQ-1)
//   req     in   per-requester request vector
//   en      in   grant enable; when low no grant is issued and state holds
//   gnt     out  one-hot-or-zero grant vector
//   gnt_idx out  index of the granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IW      = clog2_min1(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);

  logic [IW-1:0]      r_last_gnt;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_idx;
  logic               w_found;
  logic [IW-1:0]      w_cand;

  // Walk the requesters in priority order last+1, last+2, ... wrapping.
  // The offset runs to NUM_REQ inclusive so the last granted requester is
  // considered last, which is what makes the scheme fair.
  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = IW'((int'(r_last_gnt) + i) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found       = 1'b1;
        w_gnt[w_cand] = 1'b1;
        w_idx         = w_cand;
      end
    end
    if (!en) begin
      w_gnt = '0;
      w_idx = '0;
    end
  end

  assign gnt     = w_gnt;
  assign gnt_idx = w_idx;

  // Reset to NUM_REQ-1 so requester 0 is first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= IW'(NUM_REQ - 1);
    end else if (|w_gnt) begin
      r_last_gnt <= w_idx;
    end
  end

endmodule

// File: rtl/fifo_ctrl_arb.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_arb
// Controller and push-side arbiter for one shared synchronous FIFO RAM.
// NUM_REQ producers are round-robin arbitrated onto the single write port;
// pushes are blocked while full, pops are rejected while empty. The block owns
// the read/write pointers, the occupancy count and registered full/empty
// flags. The consumer drives pop directly.
//
// Optional feature: define FIFO_CTRL_ASSERT_EN to compile immediate
// assertions (grant one-hot, no push when full, no pop when empty, count
// range) checked at every rising edge outside reset. Without the macro no
// assertion code exists and behaviour is identical.
//
// Parameters:
//   NUM_REQ : producers sharing the push port (2..8)
//   DEPTH   : FIFO entries, power of 2, >= 2
//   AW      : pointer width, derived from DEPTH (do not override)
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   req      in   per-producer push request (level, held until granted)
//   gnt      out  one-hot-or-zero grant; push accepted in the same cycle
//   wr_sel   out  granted producer index (RAM write-data mux select)
//   wr_en    out  RAM write strobe (|gnt)
//   wr_addr  out  RAM write address
//   pop      in   consumer pop request
//   rd_en    out  RAM read strobe (pop accepted)
//   rd_addr  out  RAM read address
//   flush    in   synchronous clear of FIFO contents
//   err_clr  in   synchronous clear of pop_err
//   full     out  registered, count == DEPTH
//   empty    out  registered, count == 0
//   count    out  occupancy 0..DEPTH
//   pop_err  out  sticky, set on pop while empty
// -----------------------------------------------------------------------------
module fifo_ctrl_arb
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DEPTH   = FIFO_DEPTH_DEF,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [clog2_min1(NUM_REQ)-1:0] wr_sel,
  output logic                          wr_en,
  output logic [AW-1:0]                 wr_addr,
  input  logic                          pop,
  output logic                          rd_en,
  output logic [AW-1:0]                 rd_addr,
  input  logic                          flush,
  input  logic                          err_clr,
  output logic                          full,
  output logic                          empty,
  output logic [AW:0]                   count,
  output logic                          pop_err
);

  localparam int          SW        = clog2_min1(NUM_REQ);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_pop_err;

  logic               w_arb_en;
  logic [NUM_REQ-1:0] w_gnt;
  logic [SW-1:0]      w_gnt_idx;
  logic               w_push;
  logic               w_pop;
  fifo_op_e           w_op;
  logic [AW-1:0]      w_wr_ptr_next;
  logic [AW-1:0]      w_rd_ptr_next;
  logic [AW:0]        w_count_next;

  // No full-bypass: a pop in the same cycle does not open a slot for a push.
  // Flush also suppresses grants so nothing is written into a slot that is
  // about to be forgotten.
  assign w_arb_en = !r_full && !flush;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  // A pop on an empty FIFO is refused even when a push lands in the same
  // cycle; the pushed entry only becomes readable next cycle.
  assign w_push = |w_gnt;
  assign w_pop  = pop && !r_empty && !flush;
  assign w_op   = fifo_op_e'({w_pop, w_push});

  always_comb begin
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_count_next  = r_count;
    case (w_op)
      OP_PUSH: begin
        w_wr_ptr_next = r_wr_ptr + PTR_ONE;
        w_count_next  = r_count + CNT_ONE;
      end
      OP_POP: begin
        w_rd_ptr_next = r_rd_ptr + PTR_ONE;
        w_count_next  = r_count - CNT_ONE;
      end
      OP_BOTH: begin
        w_wr_ptr_next = r_wr_ptr + PTR_ONE;
        w_rd_ptr_next = r_rd_ptr + PTR_ONE;
      end
      default: begin
      end
    endcase
  end

  // Flags are computed from the next count so they change on the same edge
  // as count itself; they are never derived from pointer comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_full   <= (w_count_next == CNT_DEPTH);
      r_empty  <= (w_count_next == '0);
    end
  end

  // Sticky pop error; a new violation takes precedence over a clear.
  // Flush leaves this flag alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pop_err <= 1'b0;
    end else if (pop && r_empty) begin
      r_pop_err <= 1'b1;
    end else if (err_clr) begin
      r_pop_err <= 1'b0;
    end
  end

  assign gnt     = w_gnt;
  assign wr_sel  = w_gnt_idx;
  assign wr_en   = w_push;
  assign wr_addr = r_wr_ptr;
  assign rd_en   = w_pop;
  assign rd_addr = r_rd_ptr;
  assign full    = r_full;
  assign empty   = r_empty;
  assign count   = r_count;
  assign pop_err = r_pop_err;

`ifdef FIFO_CTRL_ASSERT_EN
  always @(posedge clk) begin
    if (!rst) begin
      a_gnt_onehot: assert ($onehot0(gnt))
        else $error("[FAIL] a_gnt_onehot at %0t", $time);
      a_no_push_full: assert (!(wr_en && full))
        else $error("[FAIL] a_no_push_full at %0t", $time);
      a_no_pop_empty: assert (!(rd_en && empty))
        else $error("[FAIL] a_no_pop_empty at %0t", $time);
      a_count_range: assert (count <= CNT_DEPTH)
        else $error("[FAIL] a_count_range at %0t", $time);
    end
  end
`else
  // Assertion checks are compiled only when FIFO_CTRL_ASSERT_EN is defined.
`endif

endmodule

// File: tb/tb_fifo_ctrl_arb.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl_arb
// Directed testbench for fifo_ctrl_arb with NUM_REQ=4, DEPTH=4.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// checked 1 unit later, registered outputs 1 unit after the following edge.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl_arb;
  import fifo_ctrl_pkg::*;

  localparam int NR = 4;
  localparam int DP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [1:0]  wr_sel;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic        pop;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic        flush;
  logic        err_clr;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        pop_err;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_ctrl_arb #(.NUM_REQ(NR), .DEPTH(DP)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .wr_sel  (wr_sel),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .pop     (pop),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .flush   (flush),
    .err_clr (err_clr),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .pop_err (pop_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] r, input logic p, input logic f, input logic c);
    req = r; pop = p; flush = f; err_clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (pop_err !== 1'b0) begin n_fail++; $display("FAIL reset_pop_err: got %b expected 0", pop_err); end
    n_checks++; if (wr_addr !== 2'd0 || rd_addr !== 2'd0) begin n_fail++; $display("FAIL reset_addr: got wr=%0d rd=%0d expected 0/0", wr_addr, rd_addr); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    tick();
    rst = 1'b0;
    $display("reset: count=%0d empty=%b full=%b", count, empty, full);
  endtask

  task automatic test_fill();
    logic [3:0] eg;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0001, 1'b0, 1'b0, 1'b0);
      #1;
      eg = (i < 4) ? 4'b0001 : 4'b0000;
      n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL fill_gnt[%0d]: got %b expected %b", i, gnt, eg); end
      n_checks++; if (wr_en !== (i < 4)) begin n_fail++; $display("FAIL fill_wr_en[%0d]: got %b expected %b", i, wr_en, (i < 4)); end
      if (i < 4) begin
        n_checks++; if (wr_addr !== 2'(i)) begin n_fail++; $display("FAIL fill_wr_addr[%0d]: got %0d expected %0d", i, wr_addr, i); end
        n_checks++; if (wr_sel !== 2'd0) begin n_fail++; $display("FAIL fill_wr_sel[%0d]: got %0d expected 0", i, wr_sel); end
      end
      tick();
      n_checks++; if (count !== 3'((i < 4) ? i + 1 : 4)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, (i < 4) ? i + 1 : 4); end
      n_checks++; if (full !== (i >= 3)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i >= 3)); end
      $display("fill %0d: gnt=%b count=%0d full=%b", i, eg, count, full);
    end
    for (int i = 0; i < 4; i++) begin
      drive(4'b0000, 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL drain_rd_en[%0d]: got %b expected 1", i, rd_en); end
      n_checks++; if (rd_addr !== 2'(i)) begin n_fail++; $display("FAIL drain_rd_addr[%0d]: got %0d expected %0d", i, rd_addr, i); end
      tick();
      n_checks++; if (count !== 3'(3 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count, 3 - i); end
      n_checks++; if (empty !== (i == 3)) begin n_fail++; $display("FAIL drain_empty[%0d]: got %b expected %b", i, empty, (i == 3)); end
      $display("drain %0d: count=%0d empty=%b", i, count, empty);
    end
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    int order[6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] eg;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(4'b1111, 1'b1, 1'b0, 1'b0);
      #1;
      eg = 4'(1 << order[i]);
      n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, eg); end
      n_checks++; if (wr_sel !== 2'(order[i])) begin n_fail++; $display("FAIL rr_wr_sel[%0d]: got %0d expected %0d", i, wr_sel, order[i]); end
      n_checks++; if (rd_en !== (i != 0)) begin n_fail++; $display("FAIL rr_rd_en[%0d]: got %b expected %b", i, rd_en, (i != 0)); end
      tick();
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL rr_count[%0d]: got %0d expected 1", i, count); end
      $display("rr %0d: gnt=%b count=%0d", i, eg, count);
    end
    n_checks++; if (pop_err !== 1'b1) begin n_fail++; $display("FAIL rr_pop_err: got %b expected 1", pop_err); end
    drive(4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    n_checks++; if (pop_err !== 1'b0) begin n_fail++; $display("FAIL rr_err_clr: got %b expected 0", pop_err); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rr_final_count: got %0d expected 0", count); end
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_pop_empty();
    apply_reset();
    drive(4'b0010, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL pe_rd_en: got %b expected 0", rd_en); end
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL pe_gnt: got %b expected 0010", gnt); end
    tick();
    n_checks++; if (pop_err !== 1'b1) begin n_fail++; $display("FAIL pe_pop_err: got %b expected 1", pop_err); end
    n_checks++; if (count !== 3'd1 || empty !== 1'b0) begin n_fail++; $display("FAIL pe_count: got %0d/%b expected 1/0", count, empty); end
    drive(4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    n_checks++; if (pop_err !== 1'b0) begin n_fail++; $display("FAIL pe_clear: got %b expected 0", pop_err); end
    drive(4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++; if (count !== 3'd0 || pop_err !== 1'b0) begin n_fail++; $display("FAIL pe_valid_pop: got count=%0d err=%b expected 0/0", count, pop_err); end
    drive(4'b0000, 1'b1, 1'b0, 1'b1);
    tick();
    n_checks++; if (pop_err !== 1'b1) begin n_fail++; $display("FAIL pe_set_wins: got %b expected 1", pop_err); end
    drive(4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    n_checks++; if (pop_err !== 1'b0) begin n_fail++; $display("FAIL pe_clear2: got %b expected 0", pop_err); end
    $display("pop_empty: done, pop_err=%b", pop_err);
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_full_pop();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(4'b0001, 1'b0, 1'b0, 1'b0);
      tick();
    end
    n_checks++; if (count !== 3'd4 || full !== 1'b1) begin n_fail++; $display("FAIL fp_filled: got %0d/%b expected 4/1", count, full); end
    drive(4'b0001, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL fp_rd_en: got %b expected 1", rd_en); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL fp_no_bypass: got %b expected 0000", gnt); end
    tick();
    n_checks++; if (count !== 3'd3 || full !== 1'b0) begin n_fail++; $display("FAIL fp_after_pop: got %0d/%b expected 3/0", count, full); end
    drive(4'b0001, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL fp_regrant: got %b expected 0001", gnt); end
    tick();
    n_checks++; if (count !== 3'd4 || full !== 1'b1) begin n_fail++; $display("FAIL fp_refill: got %0d/%b expected 4/1", count, full); end
    $display("full_pop: count=%0d full=%b", count, full);
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    fifo_op_e ops[13] = '{OP_PUSH, OP_PUSH, OP_PUSH, OP_BOTH, OP_BOTH, OP_BOTH, OP_BOTH,
                          OP_BOTH, OP_BOTH, OP_BOTH, OP_POP, OP_POP, OP_POP};
    logic [1:0] q[$];
    logic [1:0] m_wr;
    logic [1:0] exp_rd;
    int         m_cnt;
    logic       do_push;
    logic       do_pop;
    apply_reset();
    m_wr = 2'd0;
    m_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      do_push = (ops[i] == OP_PUSH) || (ops[i] == OP_BOTH);
      do_pop  = (ops[i] == OP_POP)  || (ops[i] == OP_BOTH);
      drive(do_push ? 4'b0001 : 4'b0000, do_pop, 1'b0, 1'b0);
      #1;
      n_checks++; if (wr_en !== do_push || rd_en !== do_pop) begin n_fail++; $display("FAIL wrap_strobes[%0d]: got wr=%b rd=%b expected %b/%b", i, wr_en, rd_en, do_push, do_pop); end
      if (do_pop) begin
        exp_rd = q.pop_front();
        n_checks++; if (rd_addr !== exp_rd) begin n_fail++; $display("FAIL wrap_rd_addr[%0d]: got %0d expected %0d", i, rd_addr, exp_rd); end
        m_cnt--;
      end
      if (do_push) begin
        n_checks++; if (wr_addr !== m_wr) begin n_fail++; $display("FAIL wrap_wr_addr[%0d]: got %0d expected %0d", i, wr_addr, m_wr); end
        q.push_back(m_wr);
        m_wr = m_wr + 2'd1;
        m_cnt++;
      end
      tick();
      n_checks++; if (count !== 3'(m_cnt)) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, count, m_cnt); end
      $display("wrap %0d: op=%s wr_addr=%0d rd_addr=%0d count=%0d", i, ops[i].name(), wr_addr, rd_addr, count);
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b expected 1", empty); end
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    apply_reset();
    drive(4'b0001, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL fl_pre_count: got %0d expected 2", count); end
    drive(4'b0001, 1'b1, 1'b1, 1'b0);
    #1;
    n_checks++; if (gnt !== 4'b0000 || wr_en !== 1'b0 || rd_en !== 1'b0) begin n_fail++; $display("FAIL fl_gating: got gnt=%b wr=%b rd=%b expected 0000/0/0", gnt, wr_en, rd_en); end
    tick();
    n_checks++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL fl_cleared: got %0d/%b/%b expected 0/1/0", count, empty, full); end
    n_checks++; if (wr_addr !== 2'd0 || rd_addr !== 2'd0) begin n_fail++; $display("FAIL fl_ptrs: got wr=%0d rd=%0d expected 0/0", wr_addr, rd_addr); end
    drive(4'b0001, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL fl_resume_gnt: got %b expected 0001", gnt); end
    tick();
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL fl_resume_count: got %0d expected 1", count); end
    $display("flush: count=%0d empty=%b", count, empty);
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    // Drain the single entry left by the previous test, then pop while empty.
    drive(4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    drive(4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    drive(4'b0001, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    n_checks++; if (count !== 3'd2 || pop_err !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got count=%0d err=%b expected 2/1", count, pop_err); end
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL ar_flags: got %0d/%b/%b expected 0/1/0", count, empty, full); end
    n_checks++; if (pop_err !== 1'b0) begin n_fail++; $display("FAIL ar_pop_err: got %b expected 0", pop_err); end
    n_checks++; if (wr_addr !== 2'd0 || rd_addr !== 2'd0) begin n_fail++; $display("FAIL ar_ptrs: got wr=%0d rd=%0d expected 0/0", wr_addr, rd_addr); end
    tick();
    rst = 1'b0;
    drive(4'b1111, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL ar_prio: got %b expected 0001", gnt); end
    $display("async_reset: count=%0d empty=%b", count, empty);
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    test_reset();
    test_fill();
    test_round_robin();
    test_pop_empty();
    test_full_pop();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
